// File: rtl/stream_proc_pkg.sv
// Shared definitions for stream_processor: ALU opcodes, instruction field
// layout and a one-hot helper for source selection.
package stream_proc_pkg;

   localparam int unsigned OP_ADD = 0;
   localparam int unsigned OP_SUB = 1;
   localparam int unsigned OP_AND = 2;
   localparam int unsigned OP_OR  = 3;

   // Widest source vector the one-hot helper can produce.
   localparam int MAX_SRC = 32;

   // Instruction fields, MSB first: {opcode, src0, src1, dst_mask}.
   typedef enum logic [1:0] {
      FLD_OPCODE,
      FLD_SRC0,
      FLD_SRC1,
      FLD_MASK
   } inst_field_e;

   // Bit offset of the LSB of a field inside the instruction word.
   function automatic int field_lsb(inst_field_e fld, int idx_w, int num_dst);
      int lsb;
      lsb = 0;
      case (fld)
         FLD_MASK:   lsb = 0;
         FLD_SRC1:   lsb = num_dst;
         FLD_SRC0:   lsb = num_dst + idx_w;
         default:    lsb = num_dst + 2 * idx_w;
      endcase
      return lsb;
   endfunction

   // One-hot decode of a source index; callers truncate to NUM_SRC bits.
   function automatic logic [MAX_SRC-1:0] onehot(int unsigned idx);
      return MAX_SRC'(1) << idx;
   endfunction

endpackage

// File: rtl/stream_proc_if.sv
// FIFO-facing bus of stream_processor. The master modport is the processor;
// the slave modport is the parent that owns the instruction, source and
// destination FIFOs.
interface stream_proc_if #(
   parameter int DATA_WIDTH = 4,
   parameter int NUM_SRC    = 4,
   parameter int NUM_DST    = 2,
   parameter int INST_WIDTH = 8
);
   logic [INST_WIDTH-1:0]         inst_data;
   logic                          inst_empty;
   logic                          inst_deq;
   logic [NUM_SRC*DATA_WIDTH-1:0] src_data;
   logic [NUM_SRC-1:0]            src_empty;
   logic [NUM_SRC-1:0]            src_deq;
   logic [DATA_WIDTH-1:0]         dst_data;
   logic [NUM_DST-1:0]            dst_full;
   logic [NUM_DST-1:0]            dst_enq;

   modport master (
      input  inst_data, inst_empty, src_data, src_empty, dst_full,
      output inst_deq, src_deq, dst_data, dst_enq
   );

   modport slave (
      output inst_data, inst_empty, src_data, src_empty, dst_full,
      input  inst_deq, src_deq, dst_data, dst_enq
   );
endinterface

// File: rtl/stream_proc_wb.sv
// One-deep writeback buffer. Holds one ALU result plus its destination mask
// and pushes it to every masked destination in a single cycle, only once all
// of them are non-full.
module stream_proc_wb #(
   parameter int DATA_WIDTH = 4,
   parameter int NUM_DST    = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic [NUM_DST-1:0]    load_mask,
   input  logic [NUM_DST-1:0]    dst_full,
   output logic                  wb_valid,
   output logic                  wb_drain,
   output logic [DATA_WIDTH-1:0] dst_data,
   output logic [NUM_DST-1:0]    dst_enq
);
   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] data_q,  data_d;
   logic [NUM_DST-1:0]    mask_q,  mask_d;

   // Atomic drain decision and next-state of the buffer.
   always_comb begin
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      valid_d  = valid_q;
      data_d   = data_q;
      mask_d   = mask_q;
      // A result still registered while reset is asserted is already discarded.
      wb_valid = valid_q && !reset;
      wb_drain = wb_valid && ((mask_q & dst_full) == '0);
      dst_enq  = wb_drain ? mask_q : '0;
      if (wb_drain) valid_d = 1'b0;
      // A load in the drain cycle replaces the leaving result.
      if (load) begin
         valid_d = 1'b1;
         data_d  = load_data;
         mask_d  = load_mask;
      end
   end

   // Buffer registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         mask_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         mask_q  <= mask_d;
      end
   end

   assign dst_data = data_q;

endmodule

// File: rtl/stream_processor.sv
// Stream processor: pops an instruction and up to two source heads, computes
// through a registered ALU stage and multicasts the result to a subset of
// destinations. Optional performance counters are enabled by defining
// STREAM_PROC_PERF_CNT_EN.
module stream_processor
   import stream_proc_pkg::*;
#(
   parameter int DATA_WIDTH    = 4,
   parameter int NUM_SRC       = 4,
   parameter int NUM_DST       = 2,
   parameter int OPCODE_WIDTH  = 2,
   parameter int SRC_IDX_WIDTH = $clog2(NUM_SRC),
   parameter int INST_WIDTH    = OPCODE_WIDTH + 2 * SRC_IDX_WIDTH + NUM_DST
) (
   input  logic          clk,
   input  logic          reset,
   stream_proc_if.master bus,
   output logic          busy
`ifdef STREAM_PROC_PERF_CNT_EN
   ,
   output logic [15:0]   issue_count,
   output logic [15:0]   stall_count
`endif
);
   localparam int OPC_LSB  = field_lsb(FLD_OPCODE, SRC_IDX_WIDTH, NUM_DST);
   localparam int SRC0_LSB = field_lsb(FLD_SRC0, SRC_IDX_WIDTH, NUM_DST);
   localparam int SRC1_LSB = field_lsb(FLD_SRC1, SRC_IDX_WIDTH, NUM_DST);
   localparam int MASK_LSB = field_lsb(FLD_MASK, SRC_IDX_WIDTH, NUM_DST);

   logic [OPCODE_WIDTH-1:0]  opcode;
   logic [SRC_IDX_WIDTH-1:0] src0_raw, src1_raw, sel0, sel1;
   logic [NUM_DST-1:0]       dst_mask;
   logic [DATA_WIDTH-1:0]    src_word [NUM_SRC];
   logic [DATA_WIDTH-1:0]    op0, op1, alu_result;
   logic [NUM_SRC-1:0]       need;
   logic                     src_ok, wb_free, issue;
   logic                     wb_valid, wb_drain;

   assign opcode   = bus.inst_data[OPC_LSB  +: OPCODE_WIDTH];
   assign src0_raw = bus.inst_data[SRC0_LSB +: SRC_IDX_WIDTH];
   assign src1_raw = bus.inst_data[SRC1_LSB +: SRC_IDX_WIDTH];
   assign dst_mask = bus.inst_data[MASK_LSB +: NUM_DST];

   // Decode, operand fetch, ALU and issue decision.
   always_comb begin
      for (int i = 0; i < NUM_SRC; i++) begin
         src_word[i] = bus.src_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
      // Out-of-range indices fall back to source 0.
      sel0 = (int'(src0_raw) < NUM_SRC) ? src0_raw : '0;
      sel1 = (int'(src1_raw) < NUM_SRC) ? src1_raw : '0;
      op0  = src_word[sel0];
      op1  = src_word[sel1];
      // Identical indices collapse into a single pop of that source.
      need = NUM_SRC'(onehot(32'(sel0)) | onehot(32'(sel1)));
      case (opcode)
         OPCODE_WIDTH'(OP_ADD): alu_result = op0 + op1;
         OPCODE_WIDTH'(OP_SUB): alu_result = op0 - op1;
         OPCODE_WIDTH'(OP_AND): alu_result = op0 & op1;
         OPCODE_WIDTH'(OP_OR):  alu_result = op0 | op1;
         default:               alu_result = '0;
      endcase
      src_ok       = (need & bus.src_empty) == '0;
      wb_free      = !wb_valid || wb_drain;
      issue        = !bus.inst_empty && src_ok && wb_free && !reset;
      bus.inst_deq = issue;
      bus.src_deq  = issue ? need : '0;
   end

   stream_proc_wb #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_DST    (NUM_DST)
   ) u_wb (
      .clk       (clk),
      .reset     (reset),
      .load      (issue),
      .load_data (alu_result),
      .load_mask (dst_mask),
      .dst_full  (bus.dst_full),
      .wb_valid  (wb_valid),
      .wb_drain  (wb_drain),
      .dst_data  (bus.dst_data),
      .dst_enq   (bus.dst_enq)
   );

   assign busy = wb_valid;

`ifdef STREAM_PROC_PERF_CNT_EN
   logic [15:0] issue_cnt_q, issue_cnt_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;

   // Saturating counts of issued instructions and stalled pending instructions.
   always_comb begin
      issue_cnt_d = issue_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (issue && issue_cnt_q != 16'hFFFF) issue_cnt_d = issue_cnt_q + 16'd1;
      if (!bus.inst_empty && !issue && !reset && stall_cnt_q != 16'hFFFF)
         stall_cnt_d = stall_cnt_q + 16'd1;
   end

   // Counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         issue_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         issue_cnt_q <= issue_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign issue_count = issue_cnt_q;
   assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_stream_processor.sv
// Directed bench for stream_processor (NUM_SRC=4, NUM_DST=2, DATA_WIDTH=4).
// Counter checks are compiled in when STREAM_PROC_PERF_CNT_EN is defined.
module tb_stream_processor;

   logic clk;
   logic reset;
   logic busy;
   int   checks;
   int   failures;
`ifdef STREAM_PROC_PERF_CNT_EN
   logic [15:0] issue_count;
   logic [15:0] stall_count;
`endif

   stream_proc_if #(.DATA_WIDTH(4), .NUM_SRC(4), .NUM_DST(2), .INST_WIDTH(8)) bus ();

   stream_processor #(
      .DATA_WIDTH   (4),
      .NUM_SRC      (4),
      .NUM_DST      (2),
      .OPCODE_WIDTH (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .busy  (busy)
`ifdef STREAM_PROC_PERF_CNT_EN
      ,
      .issue_count (issue_count),
      .stall_count (stall_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] mk(input logic [1:0] op, input logic [1:0] s0,
                                     input logic [1:0] s1, input logic [1:0] m);
      return {op, s0, s1, m};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(input int i, input logic [3:0] v);
      bus.src_data[i*4 +: 4] = v;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      bus.inst_empty = 1'b1;
      bus.dst_full = 2'b00;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      tick();
      tick();
      bus.inst_data = mk(2'd0, 2'd1, 2'd2, 2'b01);
      set_src(1, 4'd3);
      set_src(2, 4'd5);
      bus.inst_empty = 1'b0;
      bus.src_empty = 4'b0000;
      #1;
      checks++; if (bus.inst_deq !== 1'b0) begin failures++; $display("FAIL rst_inst_deq got=%b exp=0", bus.inst_deq); end
      checks++; if (bus.src_deq !== 4'b0000) begin failures++; $display("FAIL rst_src_deq got=%b exp=0000", bus.src_deq); end
      checks++; if (bus.dst_enq !== 2'b00) begin failures++; $display("FAIL rst_dst_enq got=%b exp=00", bus.dst_enq); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
      checks++; if (bus.dst_data !== 4'h0) begin failures++; $display("FAIL rst_dst_data got=%h exp=0", bus.dst_data); end
`ifdef STREAM_PROC_PERF_CNT_EN
      checks++; if (issue_count !== 16'd0) begin failures++; $display("FAIL rst_issue_cnt got=%0d exp=0", issue_count); end
      checks++; if (stall_count !== 16'd0) begin failures++; $display("FAIL rst_stall_cnt got=%0d exp=0", stall_count); end
`endif
      tick();
      reset = 1'b0;
      bus.inst_empty = 1'b1;
   endtask

   task automatic test_add();
      bus.inst_data = mk(2'd0, 2'd1, 2'd2, 2'b01);
      set_src(1, 4'd3);
      set_src(2, 4'd5);
      bus.inst_empty = 1'b0;
      #1;
      checks++; if (bus.inst_deq !== 1'b1) begin failures++; $display("FAIL add_inst_deq got=%b exp=1", bus.inst_deq); end
      checks++; if (bus.src_deq !== 4'b0110) begin failures++; $display("FAIL add_src_deq got=%b exp=0110", bus.src_deq); end
      tick();
      bus.inst_empty = 1'b1;
      #1;
      checks++; if (bus.dst_enq !== 2'b01) begin failures++; $display("FAIL add_dst_enq got=%b exp=01", bus.dst_enq); end
      checks++; if (bus.dst_data !== 4'h8) begin failures++; $display("FAIL add_dst_data got=%h exp=8", bus.dst_data); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL add_busy got=%b exp=1", busy); end
      checks++; if (bus.src_deq !== 4'b0000) begin failures++; $display("FAIL add_src_deq_once got=%b exp=0000", bus.src_deq); end
      tick();
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL add_idle_busy got=%b exp=0", busy); end
      checks++; if (bus.dst_enq !== 2'b00) begin failures++; $display("FAIL add_idle_enq got=%b exp=00", bus.dst_enq); end
   endtask

   task automatic test_sub_same();
      bus.inst_data = mk(2'd1, 2'd0, 2'd0, 2'b11);
      set_src(0, 4'd2);
      bus.inst_empty = 1'b0;
      #1;
      checks++; if (bus.src_deq !== 4'b0001) begin failures++; $display("FAIL sub_src_deq got=%b exp=0001", bus.src_deq); end
      checks++; if (bus.inst_deq !== 1'b1) begin failures++; $display("FAIL sub_inst_deq got=%b exp=1", bus.inst_deq); end
      tick();
      bus.inst_empty = 1'b1;
      #1;
      checks++; if (bus.dst_enq !== 2'b11) begin failures++; $display("FAIL sub_dst_enq got=%b exp=11", bus.dst_enq); end
      checks++; if (bus.dst_data !== 4'h0) begin failures++; $display("FAIL sub_dst_data got=%h exp=0", bus.dst_data); end
      tick();
   endtask

   task automatic test_and();
      bus.inst_data = mk(2'd2, 2'd3, 2'd0, 2'b10);
      set_src(3, 4'hC);
      set_src(0, 4'h6);
      bus.inst_empty = 1'b0;
      #1;
      checks++; if (bus.src_deq !== 4'b1001) begin failures++; $display("FAIL and_src_deq got=%b exp=1001", bus.src_deq); end
      tick();
      bus.inst_empty = 1'b1;
      #1;
      checks++; if (bus.dst_enq !== 2'b10) begin failures++; $display("FAIL and_dst_enq got=%b exp=10", bus.dst_enq); end
      checks++; if (bus.dst_data !== 4'h4) begin failures++; $display("FAIL and_dst_data got=%h exp=4", bus.dst_data); end
      tick();
   endtask

   task automatic test_backpressure();
      bus.dst_full = 2'b10;
      bus.inst_data = mk(2'd3, 2'd1, 2'd3, 2'b11);
      set_src(1, 4'h5);
      set_src(3, 4'hA);
      bus.inst_empty = 1'b0;
      #1;
      checks++; if (bus.inst_deq !== 1'b1) begin failures++; $display("FAIL bp_first_issue got=%b exp=1", bus.inst_deq); end
      tick();
      bus.inst_data = mk(2'd0, 2'd2, 2'd3, 2'b01);
      set_src(2, 4'h1);
      set_src(3, 4'h6);
      #1;
      for (int c = 0; c < 2; c++) begin
         checks++; if (bus.dst_enq !== 2'b00) begin failures++; $display("FAIL bp_held_enq c=%0d got=%b exp=00", c, bus.dst_enq); end
         checks++; if (bus.inst_deq !== 1'b0) begin failures++; $display("FAIL bp_stall_issue c=%0d got=%b exp=0", c, bus.inst_deq); end
         checks++; if (bus.src_deq !== 4'b0000) begin failures++; $display("FAIL bp_stall_src c=%0d got=%b exp=0000", c, bus.src_deq); end
         checks++; if (bus.dst_data !== 4'hF) begin failures++; $display("FAIL bp_held_data c=%0d got=%h exp=f", c, bus.dst_data); end
         checks++; if (busy !== 1'b1) begin failures++; $display("FAIL bp_busy c=%0d got=%b exp=1", c, busy); end
         tick();
         #1;
      end
      bus.dst_full = 2'b00;
      #1;
      checks++; if (bus.dst_enq !== 2'b11) begin failures++; $display("FAIL bp_release_enq got=%b exp=11", bus.dst_enq); end
      checks++; if (bus.dst_data !== 4'hF) begin failures++; $display("FAIL bp_release_data got=%h exp=f", bus.dst_data); end
      checks++; if (bus.inst_deq !== 1'b1) begin failures++; $display("FAIL bp_same_cycle_issue got=%b exp=1", bus.inst_deq); end
      checks++; if (bus.src_deq !== 4'b1100) begin failures++; $display("FAIL bp_same_cycle_src got=%b exp=1100", bus.src_deq); end
      tick();
      bus.inst_empty = 1'b1;
      #1;
      checks++; if (bus.dst_enq !== 2'b01) begin failures++; $display("FAIL bp_next_enq got=%b exp=01", bus.dst_enq); end
      checks++; if (bus.dst_data !== 4'h7) begin failures++; $display("FAIL bp_next_data got=%h exp=7", bus.dst_data); end
      tick();
   endtask

   task automatic test_src_empty();
      apply_reset();
      bus.inst_data = mk(2'd3, 2'd2, 2'd3, 2'b01);
      set_src(2, 4'h9);
      set_src(3, 4'h6);
      bus.src_empty = 4'b0100;
      bus.inst_empty = 1'b0;
      #1;
      for (int c = 0; c < 3; c++) begin
         checks++; if (bus.inst_deq !== 1'b0) begin failures++; $display("FAIL se_inst_deq c=%0d got=%b exp=0", c, bus.inst_deq); end
         checks++; if (bus.src_deq !== 4'b0000) begin failures++; $display("FAIL se_src_deq c=%0d got=%b exp=0000", c, bus.src_deq); end
         tick();
         #1;
      end
      bus.src_empty = 4'b0000;
      #1;
`ifdef STREAM_PROC_PERF_CNT_EN
      checks++; if (stall_count !== 16'd3) begin failures++; $display("FAIL se_stall_cnt got=%0d exp=3", stall_count); end
`endif
      checks++; if (bus.inst_deq !== 1'b1) begin failures++; $display("FAIL se_issue got=%b exp=1", bus.inst_deq); end
      checks++; if (bus.src_deq !== 4'b1100) begin failures++; $display("FAIL se_src_pop got=%b exp=1100", bus.src_deq); end
      tick();
      bus.inst_empty = 1'b1;
      #1;
      checks++; if (bus.dst_enq !== 2'b01) begin failures++; $display("FAIL se_dst_enq got=%b exp=01", bus.dst_enq); end
      checks++; if (bus.dst_data !== 4'hF) begin failures++; $display("FAIL se_dst_data got=%h exp=f", bus.dst_data); end
`ifdef STREAM_PROC_PERF_CNT_EN
      checks++; if (stall_count !== 16'd3) begin failures++; $display("FAIL se_stall_hold got=%0d exp=3", stall_count); end
`endif
      tick();
   endtask

   task automatic test_back_to_back();
      int pushes;
      logic [3:0] exp_data;
      pushes = 0;
      apply_reset();
      bus.src_empty = 4'b0000;
      bus.inst_data = mk(2'd0, 2'd0, 2'd1, 2'b10);
      for (int k = 0; k < 8; k++) begin
         set_src(0, 4'(k));
         set_src(1, 4'(k + 1));
         bus.inst_empty = 1'b0;
         #1;
         checks++; if (bus.inst_deq !== 1'b1) begin failures++; $display("FAIL b2b_issue k=%0d got=%b exp=1", k, bus.inst_deq); end
         if (k > 0) begin
            exp_data = 4'(2 * (k - 1) + 1);
            checks++; if (bus.dst_enq !== 2'b10) begin failures++; $display("FAIL b2b_enq k=%0d got=%b exp=10", k, bus.dst_enq); end
            checks++; if (bus.dst_data !== exp_data) begin failures++; $display("FAIL b2b_data k=%0d got=%h exp=%h", k, bus.dst_data, exp_data); end
            if (bus.dst_enq == 2'b10) pushes++;
         end
         tick();
      end
      bus.inst_empty = 1'b1;
      #1;
      checks++; if (bus.dst_enq !== 2'b10) begin failures++; $display("FAIL b2b_last_enq got=%b exp=10", bus.dst_enq); end
      checks++; if (bus.dst_data !== 4'hF) begin failures++; $display("FAIL b2b_last_data got=%h exp=f", bus.dst_data); end
      if (bus.dst_enq == 2'b10) pushes++;
      checks++; if (pushes != 8) begin failures++; $display("FAIL b2b_push_count got=%0d exp=8", pushes); end
`ifdef STREAM_PROC_PERF_CNT_EN
      checks++; if (issue_count !== 16'd8) begin failures++; $display("FAIL b2b_issue_cnt got=%0d exp=8", issue_count); end
      checks++; if (stall_count !== 16'd0) begin failures++; $display("FAIL b2b_stall_cnt got=%0d exp=0", stall_count); end
`endif
      tick();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle_busy got=%b exp=0", busy); end
   endtask

   task automatic test_reset_mid();
      bus.dst_full = 2'b01;
      bus.inst_data = mk(2'd0, 2'd0, 2'd1, 2'b01);
      set_src(0, 4'd1);
      set_src(1, 4'd1);
      bus.inst_empty = 1'b0;
      #1;
      checks++; if (bus.inst_deq !== 1'b1) begin failures++; $display("FAIL rm_issue got=%b exp=1", bus.inst_deq); end
      tick();
      bus.inst_empty = 1'b1;
      #1;
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rm_blocked_busy got=%b exp=1", busy); end
      checks++; if (bus.dst_enq !== 2'b00) begin failures++; $display("FAIL rm_blocked_enq got=%b exp=00", bus.dst_enq); end
      reset = 1'b1;
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rm_in_reset_busy got=%b exp=0", busy); end
      checks++; if (bus.dst_enq !== 2'b00) begin failures++; $display("FAIL rm_in_reset_enq got=%b exp=00", bus.dst_enq); end
      tick();
      reset = 1'b0;
      bus.dst_full = 2'b00;
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rm_after_busy got=%b exp=0", busy); end
      checks++; if (bus.dst_enq !== 2'b00) begin failures++; $display("FAIL rm_after_enq got=%b exp=00", bus.dst_enq); end
      checks++; if (bus.dst_data !== 4'h0) begin failures++; $display("FAIL rm_after_data got=%h exp=0", bus.dst_data); end
      bus.inst_data = mk(2'd3, 2'd2, 2'd3, 2'b11);
      set_src(2, 4'h3);
      set_src(3, 4'h4);
      bus.inst_empty = 1'b0;
      #1;
      checks++; if (bus.inst_deq !== 1'b1) begin failures++; $display("FAIL rm_new_issue got=%b exp=1", bus.inst_deq); end
      checks++; if (bus.src_deq !== 4'b1100) begin failures++; $display("FAIL rm_new_src got=%b exp=1100", bus.src_deq); end
      tick();
      bus.inst_empty = 1'b1;
      #1;
      checks++; if (bus.dst_enq !== 2'b11) begin failures++; $display("FAIL rm_new_enq got=%b exp=11", bus.dst_enq); end
      checks++; if (bus.dst_data !== 4'h7) begin failures++; $display("FAIL rm_new_data got=%h exp=7", bus.dst_data); end
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      checks         = 0;
      failures       = 0;
      reset          = 1'b1;
      bus.inst_empty = 1'b1;
      bus.inst_data  = '0;
      bus.src_data   = '0;
      bus.src_empty  = 4'b1111;
      bus.dst_full   = 2'b00;
      test_reset();
      test_add();
      test_sub_same();
      test_and();
      test_backpressure();
      test_src_empty();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/stream_processor.md
Name: stream_processor

Overview:
- Parametrised successor of the single-ALU FIFO processor.
- Pops instructions from an instruction FIFO and reads two operands from any of NUM_SRC source FIFOs.
- Computes through a registered ALU stage and broadcasts the result to any subset of NUM_DST destination FIFOs.
- Adds full/empty backpressure, one-deep writeback buffering and atomic multicast; FIFOs are instantiated by the parent.

Parameters:
- DATA_WIDTH, 4, operand/result width
- NUM_SRC, 4, number of source FIFOs (>=2)
- NUM_DST, 2, number of destination FIFOs (>=1)
- OPCODE_WIDTH, 2, opcode field width
- SRC_IDX_WIDTH, $clog2(NUM_SRC), width of each source index field
- INST_WIDTH, OPCODE_WIDTH+2*SRC_IDX_WIDTH+NUM_DST, instruction width (derived)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- inst_data  in  INST_WIDTH  head of instruction FIFO: {opcode, src0, src1, dst_mask}, MSB first
- inst_empty  in  1  instruction FIFO empty
- inst_deq  out  1  pop instruction FIFO
- src_data  in  NUM_SRC*DATA_WIDTH  heads of source FIFOs, source i at [i*DATA_WIDTH +: DATA_WIDTH]
- src_empty  in  NUM_SRC  per-source empty
- src_deq  out  NUM_SRC  per-source pop
- dst_data  out  DATA_WIDTH  result, shared by all destinations
- dst_full  in  NUM_DST  per-destination full
- dst_enq  out  NUM_DST  per-destination push
- busy  out  1  writeback stage holds a result

Behaviour:
- Interface: single clock domain, clk; reset is synchronous and active-high.
- Reset: wb_valid=0, dst_data=0. While reset is high, inst_deq, src_deq, dst_enq and busy are 0.
- ALU ops (result truncated to DATA_WIDTH):
  - 0 = add (mod 2^DATA_WIDTH)
  - 1 = sub op0-op1 (mod)
  - 2 = and
  - 3 = or
  - Opcodes >3 (when OPCODE_WIDTH>2) produce 0 but are still written.
- Source index >= NUM_SRC is treated as index 0.
- Issue stage (combinational):
  - need = onehot(src0) | onehot(src1).
  - src_ok = (need & src_empty) == 0.
  - wb_free = !wb_valid || wb_drain.
  - issue = !inst_empty && src_ok && wb_free && !reset.
- Pops on issue:
  - inst_deq = issue.
  - src_deq = need when issue, else 0.
  - src0==src1: that source pops once and both operands take the same value.
- Writeback stage:
  - On issue, register the ALU result, dst_mask and wb_valid=1.
  - wb_drain = wb_valid && ((wb_mask & dst_full) == 0).
  - dst_enq = wb_mask when wb_drain, else 0.
  - Multicast is atomic: no destination is pushed until every masked destination is non-full.
- Simultaneous drain and issue: drains the old result and loads the new one in the same cycle, giving 1 instruction/cycle throughput.
- Latency: an instruction popped at edge T appears on dst_enq in cycle T+1 if no destination is full.
- dst_mask==0: instruction and sources are consumed; wb_valid is set for one cycle, no push occurs, and it drains unconditionally.
- Blocked writeback holds dst_data and the mask stable until drained and stalls issue.
- Reset mid-operation discards the buffered result; no push occurs.
- busy = wb_valid.

Optional Feature:
- Macro STREAM_PROC_PERF_CNT_EN.
- Defined:
  - Adds outputs issue_count[15:0] and stall_count[15:0], both reset to 0.
  - issue_count increments on every issue.
  - stall_count increments each cycle with !inst_empty && !issue && !reset.
  - Both counters saturate at 16'hFFFF.
- Undefined: the ports and logic are absent; the core is otherwise identical.

Decomposition:
- Package stream_proc_pkg: opcode localparams (OP_ADD, OP_SUB, OP_AND, OP_OR), a function for the field offsets of opcode/src0/src1/dst_mask within the instruction, and a onehot helper function.
- One sub-module: stream_proc_wb, the writeback register with its atomic-drain logic.
- The ALU is an inline case statement.

Test Plan:
- NUM_SRC=4, NUM_DST=2, inst {add, src1, src2, mask 01}, src1=3, src2=5 → next cycle dst_enq=01, dst_data=8; src_deq=0110 for exactly one cycle.
- Inst {sub, src0, src0, mask 11}, src0=2 → src0 pops once; dst_data=0, dst_enq=11.
- dst_full=10 with mask 11 → dst_enq stays 0 and issue stalls. Release full → single push of both destinations; the next instruction issues the same cycle.
- src2 empty for 3 cycles under inst {or, src2, src3, mask 01} → inst_deq and src_deq stay 0; stall_count=3 with STREAM_PROC_PERF_CNT_EN.
- 8 back-to-back add instructions, all FIFOs ready → 8 pushes on 8 consecutive cycles; issue_count=8.
- Assert reset while wb_valid=1 under a blocked destination → no dst_enq, busy=0 next cycle; first instruction after reset is processed normally.
